// File: rtl/dm_arbiter.sv
// Purpose: shares one DATA_MEMORY between the CPU data port and an I/O requester, round-robin on contention.
// Latency: request seen at edge 0, grant visible in cycle 1, ack in cycle ACCESS_CYCLES; back-to-back grants, no bubble.
// Backpressure: a requester holds cs/addr/data until its one-cycle ack; cpu_wait stalls the CPU until then.
module dm_arbiter #(
    parameter int ACCESS_CYCLES = 1,   // 1..15
    parameter int AW            = 12,
    parameter int DW            = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_cs,
    input  logic          cpu_wr,
    input  logic          cpu_rd,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,
    output logic          cpu_wait,
    input  logic          io_cs,
    input  logic          io_wr,
    input  logic          io_rd,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_din,
    output logic [DW-1:0] io_dout,
    output logic          io_ack,
    output logic          dm_cs,
    output logic          dm_wr,
    output logic          dm_rd,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    input  logic [DW-1:0] dm_dout
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GNT_CPU = 2'd1;
    localparam logic [1:0] GNT_IO  = 2'd2;

    // Counter value on the final cycle of an access.
    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    logic [1:0] state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       last_io, last_io_nxt;

    logic gnt_cpu, gnt_io;
    logic cpu_done, io_done;

    assign gnt_cpu  = (state == GNT_CPU);
    assign gnt_io   = (state == GNT_IO);
    assign cpu_done = gnt_cpu & cpu_cs & (cnt == LAST_CNT);
    assign io_done  = gnt_io  & io_cs  & (cnt == LAST_CNT);

    // Pick the next grant from the live requests; on contention the port not
    // served last wins (lio=1 means IO was served last, so CPU goes next).
    function automatic logic [1:0] arbitrate(input logic c, input logic i, input logic lio);
        logic [1:0] nxt;
        if (c && i)
            nxt = lio ? GNT_CPU : GNT_IO;
        else if (c)
            nxt = GNT_CPU;
        else if (i)
            nxt = GNT_IO;
        else
            nxt = IDLE;
        return nxt;
    endfunction

    // Next-state: arbitrate from IDLE or at the done edge (so a port still
    // holding cs after its ack is simply a new request), abort on cs drop.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        last_io_nxt = last_io;
        case (state)
            IDLE: begin
                state_nxt = arbitrate(cpu_cs, io_cs, last_io);
                cnt_nxt   = 4'd0;
            end
            GNT_CPU: begin
                if (!cpu_cs) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cpu_done) begin
                    last_io_nxt = 1'b0;
                    state_nxt   = arbitrate(cpu_cs, io_cs, 1'b0);
                    cnt_nxt     = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            GNT_IO: begin
                if (!io_cs) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (io_done) begin
                    last_io_nxt = 1'b1;
                    state_nxt   = arbitrate(cpu_cs, io_cs, 1'b1);
                    cnt_nxt     = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State registers; reset favours the CPU on the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            last_io <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            last_io <= last_io_nxt;
        end
    end

    // Memory mux: granted port drives the memory directly (write beats read);
    // everything idles at zero, which reset reaches immediately via state.
    always_comb begin
        dm_cs    = 1'b0;
        dm_wr    = 1'b0;
        dm_rd    = 1'b0;
        dm_addr  = '0;
        dm_din   = '0;
        cpu_dout = '0;
        io_dout  = '0;
        if (gnt_cpu) begin
            dm_cs    = cpu_cs;
            dm_wr    = cpu_wr;
            dm_rd    = cpu_rd & ~cpu_wr;
            dm_addr  = cpu_addr;
            dm_din   = cpu_din;
            cpu_dout = dm_dout;
        end else if (gnt_io) begin
            dm_cs    = io_cs;
            dm_wr    = io_wr;
            dm_rd    = io_rd & ~io_wr;
            dm_addr  = io_addr;
            dm_din   = io_din;
            io_dout  = dm_dout;
        end
    end

    assign cpu_ack  = cpu_done;
    assign io_ack   = io_done;
    assign cpu_wait = cpu_cs & ~cpu_done;

endmodule
